switch_allocator: RTL and testbench

Per-router switch allocator that sits directly upstream of the router crossbar. It takes routed requests from the five input units (proc, east, south, west, north) and arbitrates each output port round-robin with packet locking: head through tail of one packet go out uninterrupted. It drives the crossbar's five 5-bit one-hot select codes and pops the winning input buffers. Port bit order everywhere: bit0 proc, bit1 east, bit2 south, bit3 west, bit4 north.

---
 rtl/noc_pkg.sv | 49 ++++
 rtl/switch_allocator_if.sv | 15 +
 rtl/output_arbiter.sv | 91 +++++++++
 rtl/switch_allocator.sv | 60 ++++++
 tb/tb_switch_allocator.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared router definitions: port indices, code widths, arbiter state encoding
// and the round-robin pick helper used by the output arbiters.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int CODE_W    = 5;
    localparam int PORT_W    = 3;

    localparam int P = 0;
    localparam int E = 1;
    localparam int S = 2;
    localparam int W = 3;
    localparam int N = 4;

    // After reset every pointer sits on north so proc is looked at first.
    localparam logic [PORT_W-1:0] RR_RESET = 3'd4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // True when exactly one bit of a request code is set.
    function automatic logic is_onehot(input logic [CODE_W-1:0] code);
        return $onehot(code);
    endfunction

    // First requesting port strictly after 'last' in cyclic order P,E,S,W,N.
    // Returns 'last' itself when it is the only requester (full wrap).
    function automatic logic [PORT_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                  input logic [PORT_W-1:0]    last);
        logic [PORT_W-1:0] pick;
        logic [PORT_W-1:0] idx;
        logic              found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = PORT_W'((int'(last) + k) % NUM_PORTS);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Bundle between the input units / credit logic and the switch allocator.
// Array index = port (0 proc, 1 east, 2 south, 3 west, 4 north).
interface switch_allocator_if;
    import noc_pkg::*;

    logic [NUM_PORTS-1:0][CODE_W-1:0] req;        // per input: one-hot requested output
    logic [NUM_PORTS-1:0]             tail;       // per input: head flit is last of packet
    logic [NUM_PORTS-1:0]             out_ready;  // per output: downstream credit available
    logic [NUM_PORTS-1:0]             grant;      // per input: head flit wins this cycle
    logic [NUM_PORTS-1:0][CODE_W-1:0] sel_code;   // per output: registered crossbar select

    modport master (output req, tail, out_ready, input grant, sel_code);
    modport slave  (input req, tail, out_ready, output grant, sel_code);

endinterface

// File: rtl/output_arbiter.sv
// One output port's arbiter: round-robin among requesting inputs, locked to
// the owning input from head to tail of a packet. Grant is combinational;
// sel_code is the registered copy of the grant vector for the crossbar.
module output_arbiter
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] i_req,        // valid requests for this output, own bit already 0
    input  logic [NUM_PORTS-1:0] i_tail,
    input  logic                 i_out_ready,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [CODE_W-1:0]    o_sel_code
);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic [PORT_W-1:0]    r_owner;
    logic [PORT_W-1:0]    w_owner_nxt;
    logic [PORT_W-1:0]    r_rr;
    logic [PORT_W-1:0]    w_rr_nxt;
    logic [PORT_W-1:0]    w_pick;
    logic [NUM_PORTS-1:0] w_grant;
    logic [CODE_W-1:0]    r_sel_code;

    // Grant and next state: rotate past the last winner when idle, follow the owner when locked
    always_comb begin
        w_grant     = '0;
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_pick      = rr_pick(i_req, r_rr);
        if (!rst_n) begin
            w_grant = '0;
        end else if (i_out_ready) begin
            case (r_state)
                ST_IDLE: begin
                    if (|i_req) begin
                        w_grant[w_pick] = 1'b1;
                        w_rr_nxt        = w_pick;
                        if (!i_tail[w_pick]) begin
                            w_state_nxt = ST_LOCKED;
                            w_owner_nxt = w_pick;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    // Other requesters stay blocked even if the owner has no flit now.
                    if (i_req[r_owner]) begin
                        w_grant[r_owner] = 1'b1;
                        if (i_tail[r_owner]) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end else begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, pointer and crossbar select registers; reset releases any lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= 3'd0;
            r_rr       <= RR_RESET;
            r_sel_code <= 5'b00000;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr       <= w_rr_nxt;
            r_sel_code <= w_grant;
        end
    end

    assign o_grant    = w_grant;
    assign o_sel_code = r_sel_code;

endmodule

// File: rtl/switch_allocator.sv
// Router switch allocator: filters illegal requests, hands each output its
// request vector, and merges the five arbiters' grants back per input.
module switch_allocator
    import noc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    switch_allocator_if.slave  bus
);

    logic [NUM_PORTS-1:0]                w_valid;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_arb_req;    // [output][input]
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_arb_grant;  // [output][input]
    logic [NUM_PORTS-1:0][CODE_W-1:0]    w_sel_code;
    logic [NUM_PORTS-1:0]                w_grant;

    // A request is usable only if one-hot and not a U-turn to its own port
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_valid[i] = is_onehot(bus.req[i]) && !bus.req[i][i];
        end
    end

    // Transpose valid requests into per-output vectors, own-port bit forced to 0
    always_comb begin
        w_arb_req = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_arb_req[o][i] = (o != i) && w_valid[i] && bus.req[i][o];
            end
        end
    end

    // Each input requests one output, so OR across arbiters yields at most one grant
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                w_grant[i] = w_grant[i] | w_arb_grant[o][i];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        output_arbiter u_arb (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_req       (w_arb_req[o]),
            .i_tail      (bus.tail),
            .i_out_ready (bus.out_ready[o]),
            .o_grant     (w_arb_grant[o]),
            .o_sel_code  (w_sel_code[o])
        );
    end

    assign bus.grant    = w_grant;
    assign bus.sel_code = w_sel_code;

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: directed scenarios then random
// traffic, all predicted by a per-output lock/round-robin reference model.
module tb_switch_allocator;
    import noc_pkg::*;

    typedef logic [NUM_PORTS-1:0][CODE_W-1:0] vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    switch_allocator_if bus_if ();

    switch_allocator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic [4:0] gq[$];
    vec_t       sq[$];

    // reference model state per output
    bit m_locked [5];
    int m_owner  [5];
    int m_last   [5];

    task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 5; o++) begin
            m_locked[o] = 1'b0;
            m_owner[o]  = 0;
            m_last[o]   = 4;
        end
    endtask

    // Apply one cycle of inputs at the falling edge and queue the predicted response.
    task automatic drive_cycle(input vec_t rq, input logic [4:0] tl, input logic [4:0] rdy);
        logic [4:0] eg;
        vec_t       es;
        bit         ok [5];
        int         best;
        int         bestd;
        int         d;
        @(negedge clk);
        bus_if.req       = rq;
        bus_if.tail      = tl;
        bus_if.out_ready = rdy;
        eg = '0;
        es = '0;
        for (int i = 0; i < 5; i++)
            ok[i] = ($countones(rq[i]) == 1) && (rq[i][i] == 1'b0);
        for (int o = 0; o < 5; o++) begin
            if (rdy[o]) begin
                if (m_locked[o]) begin
                    best = m_owner[o];
                    if (ok[best] && rq[best][o]) begin
                        eg[best] = 1'b1;
                        es[o][best] = 1'b1;
                        if (tl[best]) m_locked[o] = 1'b0;
                    end
                end else begin
                    // winner = candidate at smallest cyclic distance after last winner
                    best  = -1;
                    bestd = 6;
                    for (int j = 0; j < 5; j++) begin
                        if (ok[j] && rq[j][o]) begin
                            d = (j - m_last[o] + 5) % 5;
                            if (d == 0) d = 5;
                            if (d < bestd) begin
                                bestd = d;
                                best  = j;
                            end
                        end
                    end
                    if (best >= 0) begin
                        eg[best] = 1'b1;
                        es[o][best] = 1'b1;
                        m_last[o] = best;
                        if (!tl[best]) begin
                            m_locked[o] = 1'b1;
                            m_owner[o]  = best;
                        end
                    end
                end
            end
        end
        gq.push_back(eg);
        sq.push_back(es);
    endtask

    // Grant monitor: mid-cycle, after inputs have settled
    initial begin
        forever begin
            logic [4:0] e;
            @(negedge clk);
            #2;
            if (gq.size() > 0) begin
                e = gq.pop_front();
                check5("grant", bus_if.grant, e);
            end
        end
    end

    // sel_code monitor: just after the edge that registers the previous cycle's grants
    initial begin
        forever begin
            vec_t e;
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                for (int o = 0; o < 5; o++)
                    check5($sformatf("sel_code[%0d]", o), bus_if.sel_code[o], e[o]);
            end
        end
    end

    initial begin
        vec_t       rq;
        logic [4:0] tl;
        logic [4:0] rdy;
        vec_t       zero_v;
        zero_v = '0;
        bus_if.req       = '0;
        bus_if.tail      = '0;
        bus_if.out_ready = '0;
        model_reset();

        // reset: grants held low even with live requests, selects cleared
        #1 rst_n = 1'b0;
        bus_if.req[P]    = 5'b00010;
        bus_if.req[S]    = 5'b00001;
        bus_if.tail      = 5'b11111;
        bus_if.out_ready = 5'b11111;
        repeat (2) @(negedge clk);
        #2;
        check5("reset grant", bus_if.grant, 5'b00000);
        for (int o = 0; o < 5; o++)
            check5($sformatf("reset sel_code[%0d]", o), bus_if.sel_code[o], 5'b00000);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // single flit proc -> east
        rq = '0; rq[P] = 5'b00010; tl = 5'b00001; rdy = 5'b11111;
        drive_cycle(rq, tl, rdy);
        drive_cycle(zero_v, 5'b00000, rdy);

        // contention for proc: east, south, north single flits
        rq = '0; rq[E] = 5'b00001; rq[S] = 5'b00001; rq[N] = 5'b00001; tl = 5'b11111;
        repeat (6) drive_cycle(rq, tl, rdy);
        drive_cycle(zero_v, 5'b00000, rdy);

        // packet lock: west 3-flit packet to north, proc joins from cycle 1
        rq = '0; rq[W] = 5'b10000; tl = 5'b00000;
        drive_cycle(rq, tl, rdy);
        rq[P] = 5'b10000; tl[P] = 1'b1;
        drive_cycle(rq, tl, rdy);
        tl[W] = 1'b1;
        drive_cycle(rq, tl, rdy);
        rq[W] = 5'b00000;
        drive_cycle(rq, tl, rdy);
        drive_cycle(zero_v, 5'b00000, rdy);

        // backpressure on a locked south -> east packet
        rq = '0; rq[S] = 5'b00010; rq[N] = 5'b00010; tl = 5'b10000;
        drive_cycle(rq, tl, rdy);
        rdy[E] = 1'b0;
        drive_cycle(rq, tl, rdy);
        drive_cycle(rq, tl, rdy);
        rdy = 5'b11111;
        drive_cycle(rq, tl, rdy);
        tl[S] = 1'b1;
        drive_cycle(rq, tl, rdy);
        rq[S] = 5'b00000;
        drive_cycle(rq, tl, rdy);
        drive_cycle(zero_v, 5'b00000, rdy);

        // illegal requests: U-turn and non-one-hot
        rq = '0; rq[E] = 5'b00010; rq[W] = 5'b00011; tl = 5'b11111;
        repeat (2) drive_cycle(rq, tl, rdy);
        drive_cycle(zero_v, 5'b00000, rdy);

        // async reset while west holds a lock on north
        rq = '0; rq[W] = 5'b10000; tl = 5'b00000;
        drive_cycle(rq, tl, rdy);
        drive_cycle(rq, tl, rdy);
        #3 rst_n = 1'b0;
        #1;
        check5("async reset grant", bus_if.grant, 5'b00000);
        check5("async reset north sel_code", bus_if.sel_code[N], 5'b00000);
        void'(sq.pop_back());
        sq.push_back(zero_v);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        rq[P] = 5'b10000; tl[P] = 1'b1;
        drive_cycle(rq, tl, rdy);
        drive_cycle(rq, tl, rdy);
        drive_cycle(zero_v, 5'b00000, rdy);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 5; i++) begin
                case ($urandom_range(0, 9))
                    0, 1:    rq[i] = 5'b00000;
                    2:       rq[i] = 5'($urandom);
                    default: rq[i] = 5'b00001 << $urandom_range(0, 4);
                endcase
                tl[i]  = ($urandom_range(0, 2) == 0);
                rdy[i] = ($urandom_range(0, 4) != 0);
            end
            drive_cycle(rq, tl, rdy);
        end

        drive_cycle(zero_v, 5'b00000, 5'b11111);
        drive_cycle(zero_v, 5'b00000, 5'b11111);
        @(posedge clk);
        #2;
        total++;
        if (gq.size() != 0 || sq.size() != 0) begin
            bad++;
            $display("FAIL drain: grant queue %0d sel queue %0d entries left, expected 0",
                     gq.size(), sq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
